// File: rtl/invshiftrow256_pipe.sv
// invshiftrow256_pipe: registered inverse ShiftRows for a 256-bit (8-column)
// Rijndael state, with a valid/ready handshake on both sides.
// Storage is one output register (OREG) plus one skid register (SKID).
// With both registers in use, in_ready comes straight from a flop and never
// depends combinationally on out_ready.
// Optional feature: define SHIFTROW256_DIR_EN to add a 'dir' input.
// dir = 1 selects forward ShiftRows and dir = 0 selects inverse ShiftRows.
// The direction is applied when a state is accepted, so it stays with that
// state's data through SKID.

module invshiftrow256_pipe #(
    parameter int NB = 8
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef SHIFTROW256_DIR_EN
    input  logic         dir,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] sl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] sr
);

    // One row is NB bytes wide. Only NB = 8 is supported, giving 64-bit rows.
    localparam int ROW_W = 8 * NB;

    // The state encodes how many of OREG/SKID currently hold data.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [255:0] oreg;
    logic [255:0] skid;
    logic [255:0] xf;
    logic         accept;
    logic         drain;
    logic         fwd;

    // Rotate each row by its byte offset.
    // Inverse rotates right and forward rotates left.
    // Row 0 moves by half a row, so both directions are the same for it.
    function automatic logic [255:0] shift_rows(input logic [255:0] s, input logic f);
        logic [ROW_W-1:0] r0;
        logic [ROW_W-1:0] r1;
        logic [ROW_W-1:0] r2;
        logic [ROW_W-1:0] r3;
        r0 = s[0*ROW_W +: ROW_W];
        r1 = s[1*ROW_W +: ROW_W];
        r2 = s[2*ROW_W +: ROW_W];
        r3 = s[3*ROW_W +: ROW_W];
        if (f) begin
            r2 = {r2[ROW_W-9:0],  r2[ROW_W-1:ROW_W-8]};
            r1 = {r1[ROW_W-25:0], r1[ROW_W-1:ROW_W-24]};
        end else begin
            r2 = {r2[7:0],  r2[ROW_W-1:8]};
            r1 = {r1[23:0], r1[ROW_W-1:24]};
        end
        r0 = {r0[31:0], r0[ROW_W-1:32]};
        return {r3, r2, r1, r0};
    endfunction

`ifdef SHIFTROW256_DIR_EN
    assign fwd = dir;
`else
    assign fwd = 1'b0;
`endif

    assign xf     = shift_rows(sl, fwd);
    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // State register. Reset empties the pipe immediately, without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: occupancy goes up on accept and down on drain.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_next = TWO;
                end else if (drain && !accept) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs are decoded only from the state flop.
    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
    end

    // Data path. New data lands in OREG if OREG is free or draining; otherwise
    // it lands in SKID. SKID refills OREG before any later state can enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg <= '0;
            skid <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        oreg <= xf;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        oreg <= xf;
                    end else if (accept) begin
                        skid <= xf;
                    end
                end
                TWO: begin
                    if (drain) begin
                        oreg <= skid;
                    end
                end
                default: begin
                    oreg <= oreg;
                end
            endcase
        end
    end

    assign sr = oreg;

endmodule

// File: tb/tb_invshiftrow256_pipe.sv
// tb_invshiftrow256_pipe: self-checking bench for invshiftrow256_pipe.
// Inputs are driven and outputs are sampled on the falling clock edge.
// Define SHIFTROW256_DIR_EN to build and check the forward/inverse variant.

module tb_invshiftrow256_pipe;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] sl = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] sr;
    logic         dir = 1'b0;

    int error_count = 0;
    int check_count = 0;

    logic [255:0] sb_q[$];

    always #5 clk = ~clk;

    invshiftrow256_pipe #(.NB(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SHIFTROW256_DIR_EN
        .dir       (dir),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sl        (sl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sr        (sr)
    );

    // Reference model: rotate each 64-bit row with shifts.
    // d = 1 selects forward ShiftRows and d = 0 selects the inverse.
    function automatic logic [255:0] ref_xf(input logic [255:0] s, input logic d);
        logic [63:0] r0;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] r3;
        r3 = s[255:192];
        r2 = s[191:128];
        r1 = s[127:64];
        r0 = s[63:0];
        if (d) begin
            r2 = (r2 << 8)  | (r2 >> 56);
            r1 = (r1 << 24) | (r1 >> 40);
        end else begin
            r2 = (r2 >> 8)  | (r2 << 56);
            r1 = (r1 >> 24) | (r1 << 40);
        end
        r0 = (r0 >> 32) | (r0 << 32);
        return {r3, r2, r1, r0};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) begin
            v[32*k +: 32] = $urandom;
        end
        return v;
    endfunction

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive all DUT inputs for the next rising edge.
    task automatic applyStimulus(input logic v, input logic [255:0] data, input logic rdy, input logic d);
        in_valid  = v;
        sl        = data;
        out_ready = rdy;
        dir       = d;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [255:0] v1_in;
    logic [255:0] v1_out;
    logic [255:0] vec[8];
    logic [255:0] sa;
    logic [255:0] sb;
    logic [255:0] sc;
    logic [255:0] sd;
    logic [255:0] prev_sr;
    logic         prev_stall;
    logic         d_rand;
    int           guard;

    initial begin
        v1_in  = 256'hdbf201c6d42d01c6_0a01c6d42601c613_c6d43101c6532201_d54c01c6455c01c6;
        v1_out = 256'hdbf201c6d42d01c6_130a01c6d42601c6_532201c6d43101c6_455c01c6d54c01c6;
        for (int i = 0; i < 8; i++) begin
            vec[i] = rand256();
        end
        sa = rand256();
        sb = rand256();
        sc = rand256();
        sd = rand256();

        // Reset values appear while rst_n is low, before any clock edge.
        #1;
        checkOutput("reset_out_valid", 256'(out_valid), 256'd0);
        checkOutput("reset_in_ready", 256'(in_ready), 256'd1);
        checkOutput("reset_sr", sr, 256'd0);
        tick();
        rst_n = 1'b1;

        // V1: one known vector, transformed with a latency of one cycle.
        applyStimulus(1'b1, v1_in, 1'b1, 1'b0);
        tick();
        checkOutput("v1_out_valid", 256'(out_valid), 256'd1);
        checkOutput("v1_sr", sr, v1_out);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("v1_drained", 256'(out_valid), 256'd0);

        // V2: eight back-to-back states with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vec[i], 1'b1, 1'b0);
            checkOutput("v2_in_ready", 256'(in_ready), 256'd1);
            tick();
            checkOutput("v2_out_valid", 256'(out_valid), 256'd1);
            checkOutput("v2_sr", sr, ref_xf(vec[i], 1'b0));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("v2_drained", 256'(out_valid), 256'd0);

        // V3: with out_ready low, two states fill the pipe and the third waits.
        applyStimulus(1'b1, sa, 1'b0, 1'b0);
        tick();
        checkOutput("v3_sr_a", sr, ref_xf(sa, 1'b0));
        checkOutput("v3_ready_one", 256'(in_ready), 256'd1);
        applyStimulus(1'b1, sb, 1'b0, 1'b0);
        tick();
        checkOutput("v3_ready_full", 256'(in_ready), 256'd0);
        checkOutput("v3_sr_hold1", sr, ref_xf(sa, 1'b0));
        applyStimulus(1'b1, sc, 1'b0, 1'b0);
        tick();
        checkOutput("v3_ready_full2", 256'(in_ready), 256'd0);
        checkOutput("v3_sr_hold2", sr, ref_xf(sa, 1'b0));
        applyStimulus(1'b1, sc, 1'b1, 1'b0);
        tick();
        checkOutput("v3_sr_b", sr, ref_xf(sb, 1'b0));
        checkOutput("v3_ready_again", 256'(in_ready), 256'd1);
        tick();
        checkOutput("v3_sr_c", sr, ref_xf(sc, 1'b0));
        checkOutput("v3_valid_c", 256'(out_valid), 256'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("v3_drained", 256'(out_valid), 256'd0);

        // V4: fill the pipe (state TWO), then reset asynchronously between edges.
        applyStimulus(1'b1, sa, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, sb, 1'b0, 1'b0);
        tick();
        checkOutput("v4_full", 256'(in_ready), 256'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("v4_rst_out_valid", 256'(out_valid), 256'd0);
        checkOutput("v4_rst_in_ready", 256'(in_ready), 256'd1);
        checkOutput("v4_rst_sr", sr, 256'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, sd, 1'b1, 1'b0);
        tick();
        checkOutput("v4_first_accept_valid", 256'(out_valid), 256'd1);
        checkOutput("v4_first_accept_sr", sr, ref_xf(sd, 1'b0));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("v4_no_stale1", 256'(out_valid), 256'd0);
        tick();
        checkOutput("v4_no_stale2", 256'(out_valid), 256'd0);

        // V5: random handshakes checked against a scoreboard queue.
        prev_stall = 1'b0;
        prev_sr    = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (prev_stall) begin
                checkOutput("v5_stall_hold", sr, prev_sr);
            end
            checkOutput("v5_out_valid", 256'(out_valid), 256'(sb_q.size() != 0));
            checkOutput("v5_in_ready", 256'(in_ready), 256'(sb_q.size() < 2));
            d_rand = 1'b0;
`ifdef SHIFTROW256_DIR_EN
            d_rand = 1'($urandom_range(0, 1));
`endif
            applyStimulus(($urandom_range(0, 9) < 7), rand256(), ($urandom_range(0, 9) < 6), d_rand);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("v5_unexpected", 256'd1, 256'd0);
                end else begin
                    checkOutput("v5_data", sr, sb_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_xf(sl, dir));
            end
            prev_stall = out_valid && !out_ready;
            prev_sr    = sr;
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        guard = 0;
        while (sb_q.size() != 0 && guard < 10) begin
            checkOutput("v5_drain_valid", 256'(out_valid), 256'd1);
            checkOutput("v5_drain_data", sr, sb_q.pop_front());
            tick();
            guard++;
        end
        checkOutput("v5_queue_empty", 256'(sb_q.size()), 256'd0);
        checkOutput("v5_final_idle", 256'(out_valid), 256'd0);

`ifdef SHIFTROW256_DIR_EN
        // V6: forward ShiftRows undoes the V1 vector, and the direction can
        // alternate from one state to the next.
        applyStimulus(1'b1, v1_out, 1'b1, 1'b1);
        tick();
        checkOutput("v6_forward", sr, v1_in);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vec[i], 1'b1, 1'(i % 2));
            tick();
            checkOutput("v6_alternate", sr, ref_xf(vec[i], 1'(i % 2)));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("v6_drained", 256'(out_valid), 256'd0);
`endif

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
